hdmi_pixel_inject: RTL and testbench

//  Wishbone-controlled pixel injector on the HDMI output path: replaces one chosen pixel per frame

---
 rtl/hdmi_pixel_inject_if.sv | 22 ++
 rtl/hdmi_pixel_inject.sv | 162 ++++++++++++++++
 tb/tb_hdmi_pixel_inject.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_pixel_inject_if.sv
// Wishbone register-bus bundle for the HDMI pixel injector.
// The master drives the strobes and write data; the slave returns ack, stall and read data.
interface hdmi_pixel_inject_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [1:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_ack;
  logic        wb_stall;
  logic [31:0] wb_rdata;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata,
    input  wb_ack, wb_stall, wb_rdata
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata,
    output wb_ack, wb_stall, wb_rdata
  );
endinterface

// File: rtl/hdmi_pixel_inject.sv
// Replaces one pixel per frame on the HDMI path with a programmed {R,G,B} value,
// either once (armed one-shot) or every frame, under Wishbone control.
module hdmi_pixel_inject #(
  parameter int          CLKBITS        = 30,
  parameter int unsigned DEF_FRAME_CLKS = 2474999
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [9:0]       i_hdmi_r,
  input  logic [9:0]       i_hdmi_g,
  input  logic [9:0]       i_hdmi_b,
  output logic [9:0]       o_hdmi_r,
  output logic [9:0]       o_hdmi_g,
  output logic [9:0]       o_hdmi_b,
  hdmi_pixel_inject_if.slave wb
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ONESHOT = 2'd1,
    ST_PERSIST = 2'd2
  } state_t;

  localparam logic [CLKBITS-1:0] FRAME_RST = CLKBITS'(DEF_FRAME_CLKS);
  localparam logic [1:0] A_FRAME = 2'd0;
  localparam logic [1:0] A_POS   = 2'd1;
  localparam logic [1:0] A_VALUE = 2'd2;
  localparam logic [1:0] A_CTRL  = 2'd3;

  logic [CLKBITS-1:0] r_frame_clks;
  logic [CLKBITS-1:0] r_pixel_pos;
  logic [CLKBITS-1:0] r_counter;
  logic [29:0]        r_inj_val;
  logic [29:0]        r_pix;
  logic [15:0]        r_inj_count;
  state_t             r_state;
  state_t             w_state_next;

  logic        w_wr;
  logic        w_frame_wr;
  logic        w_pos_wr;
  logic        w_value_wr;
  logic        w_ctrl_wr;
  logic        w_zero_cnt;
  logic        w_clr_inj;
  logic        w_hit;
  logic [29:0] w_pix_in;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_wr       = wb.wb_cyc && wb.wb_stb && wb.wb_we;
  assign w_frame_wr = w_wr && (wb.wb_addr == A_FRAME);
  assign w_pos_wr   = w_wr && (wb.wb_addr == A_POS);
  assign w_value_wr = w_wr && (wb.wb_addr == A_VALUE);
  assign w_ctrl_wr  = w_wr && (wb.wb_addr == A_CTRL);
  assign w_zero_cnt = w_ctrl_wr && wb.wb_wdata[3];
  assign w_clr_inj  = w_ctrl_wr && wb.wb_wdata[2];

  // Hit uses only registered state, so any same-cycle write takes effect next clock.
  assign w_hit = (r_state != ST_IDLE) && (r_counter == r_pixel_pos);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_frame_clks <= FRAME_RST;
      r_pixel_pos  <= '0;
      r_inj_val    <= '0;
    end else begin
      if (w_frame_wr) r_frame_clks <= wb.wb_wdata[CLKBITS-1:0];
      if (w_pos_wr)   r_pixel_pos  <= wb.wb_wdata[CLKBITS-1:0];
      if (w_value_wr) r_inj_val    <= wb.wb_wdata[29:0];
    end
  end

  // The >= compare (rather than ==) makes a shortened frame wrap immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_counter <= '0;
    end else if (w_zero_cnt) begin
      r_counter <= '0;
    end else if (r_counter < r_frame_clks) begin
      r_counter <= r_counter + 1'b1;
    end else begin
      r_counter <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_inj_count <= '0;
    end else if (w_clr_inj) begin
      r_inj_count <= '0;
    end else if (w_hit && (r_inj_count != 16'hffff)) begin
      r_inj_count <= r_inj_count + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if ((r_state == ST_ONESHOT) && w_hit) begin
      w_state_next = ST_IDLE;
    end
    if (w_ctrl_wr) begin
      if (wb.wb_wdata[0]) begin
        w_state_next = ST_PERSIST;
      end else if (wb.wb_wdata[1]) begin
        w_state_next = ST_ONESHOT;
      end else begin
        w_state_next = ST_IDLE;
      end
    end
  end

  assign w_pix_in = {i_hdmi_r, i_hdmi_g, i_hdmi_b};

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_pix[gi*10 +: 10] <= '0;
      end else if (w_hit) begin
        r_pix[gi*10 +: 10] <= r_inj_val[gi*10 +: 10];
      end else begin
        r_pix[gi*10 +: 10] <= w_pix_in[gi*10 +: 10];
      end
    end
  end

  assign {o_hdmi_r, o_hdmi_g, o_hdmi_b} = r_pix;

  always_comb begin
    w_rd_mux = '0;
    case (wb.wb_addr)
      A_FRAME: w_rd_mux = 32'(r_frame_clks);
      A_POS:   w_rd_mux = 32'(r_pixel_pos);
      A_VALUE: w_rd_mux = {2'b00, r_inj_val};
      A_CTRL:  w_rd_mux = {(r_state == ST_ONESHOT), (r_state == ST_PERSIST), 14'h0, r_inj_count};
      default: w_rd_mux = '0;
    endcase
  end

  // Read data is sampled every clock regardless of strobe; a read that coincides with a write sees the old value.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wb.wb_ack   <= 1'b0;
      wb.wb_rdata <= '0;
    end else begin
      wb.wb_ack   <= wb.wb_stb;
      wb.wb_rdata <= w_rd_mux;
    end
  end

  assign wb.wb_stall = 1'b0;
  assign w_unused    = &{1'b0, wb.wb_wdata[31:30]};

endmodule

// File: tb/tb_hdmi_pixel_inject.sv
// Directed bench for hdmi_pixel_inject: register table plus hand-built video sequences.
module tb_hdmi_pixel_inject;

  localparam int unsigned DEF = 2474999;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hr, hg, hb;
  logic [9:0] vo_r, vo_g, vo_b;

  hdmi_pixel_inject_if wb();

  hdmi_pixel_inject #(
    .CLKBITS        (30),
    .DEF_FRAME_CLKS (DEF)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_hdmi_r (hr),
    .i_hdmi_g (hg),
    .i_hdmi_b (hb),
    .o_hdmi_r (vo_r),
    .o_hdmi_g (vo_g),
    .o_hdmi_b (vo_b),
    .wb       (wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } reg_vec_t;

  reg_vec_t vt[12];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    wb.wb_cyc   = 1'b0;
    wb.wb_stb   = 1'b0;
    wb.wb_we    = 1'b0;
    wb.wb_wdata = '0;
  endtask

  task automatic bus_wr_drive(input logic [1:0] a, input logic [31:0] d);
    wb.wb_cyc   = 1'b1;
    wb.wb_stb   = 1'b1;
    wb.wb_we    = 1'b1;
    wb.wb_addr  = a;
    wb.wb_wdata = d;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    bus_wr_drive(a, d);
    @(posedge clk); #1;
    bus_idle();
    check("wr_ack", {31'b0, wb.wb_ack}, 32'd1);
    $display("wr  addr=%0d data=%h", a, d);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    wb.wb_cyc  = 1'b1;
    wb.wb_stb  = 1'b1;
    wb.wb_we   = 1'b0;
    wb.wb_addr = a;
    @(posedge clk); #1;
    d = wb.wb_rdata;
    bus_idle();
    $display("rd  addr=%0d data=%h", a, d);
  endtask

  function automatic logic [29:0] pat(input int c);
    logic [31:0] t;
    t = 32'(c) * 32'h0137_9BDF + 32'h0000_0015;
    return t[29:0];
  endfunction

  // Drive one pixel, then compare the pixel that emerges one clock later.
  task automatic pix_step(input string name, input int c, input logic inj, input logic [29:0] v);
    logic [29:0] p;
    logic [29:0] e;
    p = pat(c);
    {hr, hg, hb} = p;
    @(posedge clk); #1;
    e = inj ? v : p;
    check(name, {2'b00, vo_r, vo_g, vo_b}, {2'b00, e});
    $display("pix cyc=%0d in=%h out=%h exp=%h", c, p, {vo_r, vo_g, vo_b}, e);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;

    vt[0]  = '{1'b0, 2'd0, 32'h0,         32'(DEF)};
    vt[1]  = '{1'b0, 2'd1, 32'h0,         32'h0};
    vt[2]  = '{1'b0, 2'd2, 32'h0,         32'h0};
    vt[3]  = '{1'b0, 2'd3, 32'h0,         32'h0};
    vt[4]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h3FFF_FFFF};
    vt[5]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h3FFF_FFFF};
    vt[6]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h3FFF_FFFF};
    vt[7]  = '{1'b1, 2'd3, 32'h0000_0001, 32'h4000_0000};
    vt[8]  = '{1'b1, 2'd3, 32'h0000_0002, 32'h8000_0000};
    vt[9]  = '{1'b1, 2'd3, 32'h0000_0003, 32'h4000_0000};
    vt[10] = '{1'b1, 2'd3, 32'h0000_0000, 32'h0000_0000};
    vt[11] = '{1'b1, 2'd2, 32'hC00A_BCDE, 32'h000A_BCDE};

    rst = 1'b1;
    wb.wb_addr = 2'd3;
    bus_idle();
    {hr, hg, hb} = 30'h2AAA_AAAA;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix",   {2'b00, vo_r, vo_g, vo_b}, 32'h0);
    check("rst_ack",   {31'b0, wb.wb_ack}, 32'h0);
    check("rst_rdata", wb.wb_rdata, 32'h0);
    check("stall",     {31'b0, wb.wb_stall}, 32'h0);
    rst = 1'b0;

    // Register table: optional write, then read back.
    for (int i = 0; i < 12; i++) begin
      if (vt[i].we) wb_write(vt[i].addr, vt[i].wdata);
      wb_read(vt[i].addr, d);
      check($sformatf("reg_vec%0d", i), d, vt[i].exp_rd);
    end

    // Read coinciding with a write returns the previous value.
    bus_wr_drive(2'd1, 32'h0000_0007);
    @(posedge clk); #1;
    bus_idle();
    check("rd_old", wb.wb_rdata, 32'h3FFF_FFFF);
    wb_read(2'd1, d);
    check("rd_new", d, 32'h0000_0007);

    // Persistent injection, 10-clock frame, position 3.
    wb_write(2'd0, 32'd9);
    wb_write(2'd1, 32'd3);
    wb_write(2'd2, 32'h3FF0_0000);
    wb_write(2'd3, 32'h9);
    for (int c = 0; c < 30; c++) pix_step("persist_pix", c, (c % 10) == 3, 30'h3FF0_0000);
    wb_write(2'd3, 32'h0);
    wb_read(2'd3, d);
    check("persist_cnt", d, 32'h0000_0003);

    // One-shot at position 5.
    wb_write(2'd3, 32'h4);
    wb_write(2'd2, 32'h000F_FC00);
    wb_write(2'd1, 32'd5);
    wb_write(2'd3, 32'hA);
    wb_read(2'd3, d);
    check("oneshot_armed", d, 32'h8000_0000);
    for (int c = 1; c < 25; c++) pix_step("oneshot_pix", c, c == 5, 30'h000F_FC00);
    wb_read(2'd3, d);
    check("oneshot_done", d, 32'h0000_0001);

    // One-shot cancelled before the counter reaches the position.
    wb_write(2'd3, 32'hA);
    wb_write(2'd3, 32'h0);
    for (int c = 1; c < 25; c++) pix_step("cancel_pix", c, 1'b0, 30'h000F_FC00);
    wb_read(2'd3, d);
    check("cancel_cnt", d, 32'h0000_0001);

    // Position beyond frame length: never hits, stays armed.
    wb_write(2'd0, 32'd3);
    wb_write(2'd1, 32'd5);
    wb_write(2'd3, 32'hA);
    for (int c = 0; c < 20; c++) pix_step("pos_gt_frame_pix", c, 1'b0, 30'h000F_FC00);
    wb_read(2'd3, d);
    check("pos_gt_frame_armed", d, 32'h8000_0001);
    wb_write(2'd3, 32'h0);

    // Frame shortened from 9 to 2 so it takes effect while counter is 7.
    wb_write(2'd0, 32'd9);
    wb_write(2'd1, 32'd0);
    wb_write(2'd2, 32'h0000_03FF);
    wb_write(2'd3, 32'h9);
    for (int c = 0; c < 21; c++) begin
      if (c == 6) bus_wr_drive(2'd0, 32'd2);
      pix_step("shrink_pix", c, (c == 0) || (c >= 8 && ((c - 8) % 3) == 0), 30'h0000_03FF);
      if (c == 6) bus_idle();
    end
    wb_write(2'd3, 32'h0);

    // Saturation of the injection counter: a hit on every clock.
    wb_write(2'd0, 32'd0);
    wb_write(2'd1, 32'd0);
    wb_write(2'd2, 32'h1555_5555);
    wb_write(2'd3, 32'h5);
    repeat (65534) @(posedge clk);
    #1;
    wb_read(2'd3, d);
    check("sat_fffe", d, 32'h4000_FFFE);
    repeat (5) @(posedge clk);
    #1;
    wb_read(2'd3, d);
    check("sat_ffff", d, 32'h4000_FFFF);
    wb_write(2'd3, 32'h5);
    wb_read(2'd3, d);
    check("clr_over_hit", d, 32'h4000_0000);
    wb_write(2'd3, 32'h0);

    // Reset asserted while an injected pixel is on the output.
    wb_write(2'd0, 32'd9);
    wb_write(2'd1, 32'd3);
    wb_write(2'd2, 32'h3FF0_0000);
    wb_write(2'd3, 32'h9);
    for (int c = 0; c < 4; c++) pix_step("pre_rst_pix", c, c == 3, 30'h3FF0_0000);
    wb.wb_addr = 2'd3;
    rst = 1'b1;
    #1;
    check("async_rst_pix",   {2'b00, vo_r, vo_g, vo_b}, 32'h0);
    check("async_rst_rdata", wb.wb_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wb_read(2'd0, d);
    check("post_rst_frame", d, 32'(DEF));
    wb_read(2'd3, d);
    check("post_rst_ctrl", d, 32'h0);
    for (int c = 0; c < 30; c++) pix_step("post_rst_pix", c, 1'b0, 30'h3FF0_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
